mmcm_reset_ctrl: RTL and testbench

- Upstream reset/lock sequencer for the MMCME2_BASE clocking primitive.
- Drives the MMCM RST and PWRDWN pins and monitors LOCKED.
- Retries lock acquisition on timeout and releases a filtered, delayed system reset once the clock is stable.
- Runs on a free-running reference clock, the same one that feeds CLKIN1.

---
 rtl/mmcm_rst_pkg.sv | 26 ++
 rtl/mmcm_lock_sync.sv | 33 +++
 rtl/mmcm_reset_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mmcm_reset_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_rst_pkg.sv
// mmcm_rst_pkg: shared definitions for the MMCM reset/lock sequencer.
//   - state_e       : sequencer state encoding
//   - DEF_*         : default values for the top-level parameters
//   - SYNC_STAGES   : depth of the LOCKED synchronizer
package mmcm_rst_pkg;

    localparam int unsigned SYNC_STAGES              = 2;

    localparam int unsigned DEF_RST_HOLD_CYCLES      = 16;
    localparam int unsigned DEF_LOCK_FILTER_CYCLES   = 8;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES  = 4096;
    localparam int unsigned DEF_RELEASE_DELAY_CYCLES = 32;
    localparam int unsigned DEF_MAX_RETRIES          = 3;
    localparam int unsigned DEF_CNT_W                = 16;
    localparam int unsigned DEF_RETRY_W              = 2;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_PWRDN     = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

endpackage

// File: rtl/mmcm_lock_sync.sv
// mmcm_lock_sync: N-flop single-bit synchronizer with synchronous reset to 0.
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous input bit
//   q   : synchronized output (last flop of the chain)
module mmcm_lock_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw bit in at the LSB; the MSB is the settled copy.
    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mmcm_reset_ctrl.sv
// mmcm_reset_ctrl: reset/lock sequencer for an MMCME2_BASE.
//   CLK          : free-running reference clock (same as CLKIN1)
//   RST          : synchronous active-high reset
//   PWRDWN_REQ   : request to power the MMCM down
//   MMCM_LOCKED  : LOCKED from the MMCM, asynchronous to CLK
//   MMCM_RST     : MMCM RST pin
//   MMCM_PWRDWN  : MMCM PWRDWN pin
//   SYS_RST      : active-high reset for logic on the MMCM output clocks
//   READY        : high while running with a stable lock
//   FAULT        : sticky, lock never acquired within the retry budget
//   RETRY_CNT    : lock timeouts since the last RUN or RST
module mmcm_reset_ctrl
    import mmcm_rst_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES      = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LOCK_FILTER_CYCLES   = DEF_LOCK_FILTER_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned RELEASE_DELAY_CYCLES = DEF_RELEASE_DELAY_CYCLES,
    parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W                = DEF_CNT_W,
    parameter int unsigned RETRY_W              = DEF_RETRY_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PWRDWN_REQ,
    input  logic               MMCM_LOCKED,
    output logic               MMCM_RST,
    output logic               MMCM_PWRDWN,
    output logic               SYS_RST,
    output logic               READY,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_CNT
);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REL_LAST  = CNT_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0]   FILT_DONE = CNT_W'(LOCK_FILTER_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic locked_s;

    mmcm_lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .d   (MMCM_LOCKED),
        .q   (locked_s)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;     // shared per-state cycle counter
    logic [CNT_W-1:0]   filt_q, filt_d;   // consecutive locked_s highs in WAIT_LOCK
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic mmcm_rst_q, mmcm_rst_d;
    logic sys_rst_q, sys_rst_d;
    logic pwrdwn_q, pwrdwn_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        filt_d  = filt_q;

        if (PWRDWN_REQ && (state_q != ST_FAULT)) begin
            state_d = ST_PWRDN;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q >= HOLD_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // A completed filter beats a timeout landing on the same cycle.
                    if (filt_q >= FILT_DONE) begin
                        state_d = ST_RELEASE;
                    end else if (cnt_q >= TMO_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                    // A LOCKED glitch only restarts the filter, never the timeout.
                    if (!locked_s)               filt_d = '0;
                    else if (filt_q < FILT_DONE) filt_d = filt_q + 1'b1;
                end
                ST_RELEASE: begin
                    if (!locked_s)              state_d = ST_HOLD;
                    else if (cnt_q >= REL_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) state_d = ST_HOLD;
                end
                ST_PWRDN: begin
                    state_d = ST_HOLD;  // request already known to be low here
                end
                ST_FAULT: ;
                default: state_d = ST_HOLD;
            endcase
        end

        if (state_d == ST_RUN) retry_d = '0;

        // Counters restart on every state change and saturate otherwise.
        if (state_d != state_q) begin
            cnt_d  = '0;
            filt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state so each pin changes on the
    // same edge as the state it belongs to.
    always_comb begin
        mmcm_rst_d = 1'b1;
        sys_rst_d  = 1'b1;
        pwrdwn_d   = 1'b0;
        ready_d    = 1'b0;
        fault_d    = 1'b0;
        case (state_d)
            ST_WAIT_LOCK, ST_RELEASE: mmcm_rst_d = 1'b0;
            ST_RUN: begin
                mmcm_rst_d = 1'b0;
                sys_rst_d  = 1'b0;
                ready_d    = 1'b1;
            end
            ST_PWRDN: pwrdwn_d = 1'b1;
            ST_FAULT: fault_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            filt_q     <= '0;
            retry_q    <= '0;
            mmcm_rst_q <= 1'b1;
            sys_rst_q  <= 1'b1;
            pwrdwn_q   <= 1'b0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            retry_q    <= retry_d;
            mmcm_rst_q <= mmcm_rst_d;
            sys_rst_q  <= sys_rst_d;
            pwrdwn_q   <= pwrdwn_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign MMCM_RST    = mmcm_rst_q;
    assign MMCM_PWRDWN = pwrdwn_q;
    assign SYS_RST     = sys_rst_q;
    assign READY       = ready_q;
    assign FAULT       = fault_q;
    assign RETRY_CNT   = retry_q;

endmodule

// File: tb/tb_mmcm_reset_ctrl.sv
// tb_mmcm_reset_ctrl: directed scenarios with randomized delays/patterns for
// mmcm_reset_ctrl; expectations come from timing arithmetic on the parameters.
module tb_mmcm_reset_ctrl;

    localparam int HOLD = 4;
    localparam int FILT = 3;
    localparam int TMO  = 20;
    localparam int REL  = 5;
    localparam int MAXR = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PWRDWN_REQ = 1'b0;
    logic       MMCM_LOCKED = 1'b0;
    logic       MMCM_RST, MMCM_PWRDWN, SYS_RST, READY, FAULT;
    logic [1:0] RETRY_CNT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mmcm_reset_ctrl #(
        .RST_HOLD_CYCLES      (HOLD),
        .LOCK_FILTER_CYCLES   (FILT),
        .LOCK_TIMEOUT_CYCLES  (TMO),
        .RELEASE_DELAY_CYCLES (REL),
        .MAX_RETRIES          (MAXR),
        .CNT_W                (16),
        .RETRY_W              (2)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PWRDWN_REQ  (PWRDWN_REQ),
        .MMCM_LOCKED (MMCM_LOCKED),
        .MMCM_RST    (MMCM_RST),
        .MMCM_PWRDWN (MMCM_PWRDWN),
        .SYS_RST     (SYS_RST),
        .READY       (READY),
        .FAULT       (FAULT),
        .RETRY_CNT   (RETRY_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    // After step() the sample reflects edge number cyc.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves the sample taken after a reset edge; RST is released for the next edge.
    task automatic do_reset();
        RST = 1'b1; PWRDWN_REQ = 1'b0; MMCM_LOCKED = 1'b0;
        step(); step();
        RST = 1'b0;
    endtask

    // Counts consecutive samples with MMCM_RST high, starting at the current one.
    task automatic count_rst_high(output int n);
        n = 0;
        while (MMCM_RST === 1'b1 && n < 64) begin
            n++;
            step();
        end
    endtask

    task automatic wait_sys_low(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (SYS_RST === 1'b0) begin at = cyc; break; end
            step();
        end
    endtask

    task automatic wait_rst_high(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (MMCM_RST === 1'b1) begin at = cyc; break; end
            step();
        end
    endtask

    // Raise LOCKED k cycles from now; SYS_RST must fall 2+FILT+REL edges after
    // the first edge that samples it high.
    task automatic lock_after(input string tag, input int k);
        int e0, at;
        repeat (k) step();
        MMCM_LOCKED = 1'b1;
        e0 = cyc + 1;
        wait_sys_low(64, at);
        chkn({tag, "_latency"}, at, e0 + 2 + FILT + REL);
        chk1({tag, "_ready"}, READY, 1'b1);
        chk1({tag, "_mmcm_rst"}, MMCM_RST, 1'b0);
        chkn({tag, "_retry"}, int'(RETRY_CNT), 0);
    endtask

    initial begin
        int n, at, w0, k, run, b, retries;
        logic fault_m;

        // Reset values
        do_reset();
        chk1("rst_mmcm_rst", MMCM_RST, 1'b1);
        chk1("rst_sys_rst", SYS_RST, 1'b1);
        chk1("rst_pwrdwn", MMCM_PWRDWN, 1'b0);
        chk1("rst_ready", READY, 1'b0);
        chk1("rst_fault", FAULT, 1'b0);
        chkn("rst_retry", int'(RETRY_CNT), 0);

        // Clean lock
        count_rst_high(n);
        chkn("clean_hold_len", n, HOLD);
        lock_after("clean", 6);

        // Retry, power-down in WAIT_LOCK keeps RETRY_CNT, then lock
        do_reset();
        count_rst_high(n);
        w0 = cyc;
        wait_rst_high(64, at);
        chkn("retry_timeout", at, w0 + TMO);
        chkn("retry_cnt1", int'(RETRY_CNT), 1);
        count_rst_high(n);
        chkn("retry_hold_len", n, HOLD);
        repeat ($urandom_range(1, 5)) step();
        PWRDWN_REQ = 1'b1;
        step();
        chk1("wpd_pwrdwn", MMCM_PWRDWN, 1'b1);
        chk1("wpd_mmcm_rst", MMCM_RST, 1'b1);
        chkn("wpd_retry", int'(RETRY_CNT), 1);
        PWRDWN_REQ = 1'b0;
        step();
        chk1("wpd_exit_pwrdwn", MMCM_PWRDWN, 1'b0);
        chkn("wpd_exit_retry", int'(RETRY_CNT), 1);
        count_rst_high(n);
        chkn("wpd_hold_len", n, HOLD);
        lock_after("retry", $urandom_range(0, 8));

        // Fault after MAXR+1 timeouts
        do_reset();
        retries = 0;
        fault_m = 1'b0;
        for (int t = 0; t <= MAXR; t++) begin
            count_rst_high(n);
            chkn("fault_hold_len", n, HOLD);
            w0 = cyc;
            wait_rst_high(64, at);
            chkn("fault_timeout", at, w0 + TMO);
            if (retries < MAXR) retries++;
            else fault_m = 1'b1;
            chkn("fault_retry", int'(RETRY_CNT), retries);
            chk1("fault_flag", FAULT, fault_m);
        end
        chk1("fault_sys_rst", SYS_RST, 1'b1);
        chk1("fault_ready", READY, 1'b0);
        PWRDWN_REQ = 1'b1;
        repeat (3) step();
        chk1("fault_pwrdwn_ignored", MMCM_PWRDWN, 1'b0);
        chk1("fault_sticky", FAULT, 1'b1);
        PWRDWN_REQ = 1'b0;
        RST = 1'b1;
        step();
        chk1("fault_rst_fault", FAULT, 1'b0);
        chkn("fault_rst_retry", int'(RETRY_CNT), 0);
        chk1("fault_rst_mmcm_rst", MMCM_RST, 1'b1);
        chk1("fault_rst_sys_rst", SYS_RST, 1'b1);

        // Lock loss in RUN
        do_reset();
        count_rst_high(n);
        lock_after("loss_pre", $urandom_range(0, 8));
        repeat ($urandom_range(1, 6)) step();
        MMCM_LOCKED = 1'b0;
        step();
        MMCM_LOCKED = 1'b1;
        chk1("loss_ready_e1", READY, 1'b1);
        step();
        chk1("loss_ready_e2", READY, 1'b1);
        step();
        chk1("loss_sys_rst_e3", SYS_RST, 1'b1);
        chk1("loss_ready_e3", READY, 1'b0);
        chk1("loss_mmcm_rst_e3", MMCM_RST, 1'b1);
        count_rst_high(n);
        chkn("loss_hold_len", n, HOLD);
        wait_sys_low(64, at);
        chk1("loss_relock_ready", READY, 1'b1);

        // Glitch restarts the filter; lock counted from the final rise
        do_reset();
        count_rst_high(n);
        k = $urandom_range(0, 3);
        repeat (k) step();
        MMCM_LOCKED = 1'b1;
        step(); step();
        MMCM_LOCKED = 1'b0;
        step();
        lock_after("glitch", 0);

        // Chatter never reaching the filter length: timeout keeps running
        do_reset();
        count_rst_high(n);
        w0 = cyc;
        run = 0;
        at = -1;
        for (int i = 0; i < 64; i++) begin
            b = (run < FILT - 1) ? int'($urandom_range(0, 1)) : 0;
            MMCM_LOCKED = (b != 0);
            run = (b != 0) ? run + 1 : 0;
            step();
            if (MMCM_RST === 1'b1) begin at = cyc; break; end
        end
        chkn("chatter_timeout", at, w0 + TMO);
        chkn("chatter_retry", int'(RETRY_CNT), 1);

        // Power-down from RUN
        do_reset();
        count_rst_high(n);
        lock_after("pd_pre", $urandom_range(0, 8));
        PWRDWN_REQ = 1'b1;
        step();
        chk1("pd_pwrdwn", MMCM_PWRDWN, 1'b1);
        chk1("pd_mmcm_rst", MMCM_RST, 1'b1);
        chk1("pd_sys_rst", SYS_RST, 1'b1);
        chk1("pd_ready", READY, 1'b0);
        repeat ($urandom_range(1, 4)) step();
        chk1("pd_pwrdwn_hold", MMCM_PWRDWN, 1'b1);
        PWRDWN_REQ = 1'b0;
        step();
        chk1("pd_exit_pwrdwn", MMCM_PWRDWN, 1'b0);
        count_rst_high(n);
        chkn("pd_hold_len", n, HOLD);
        wait_sys_low(64, at);
        chk1("pd_relock_ready", READY, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
